// File: rtl/decompress_ctrl.sv
// Sequencer for the decompressor datapath: clears the address counter, walks packed words,
// loads staging registers and steers the output mux. Header beats enabled by DECOMP_HEADER_EN.
//
// state | meaning
// IDLE  | waiting for start
// CLR   | zero datapath address counter
// HDR_W | width header beat (sel 0)
// HDR_H | height header beat (sel 1)
// RDn   | memory read of word n of the pair group
// LDn   | load staging register n, advance counter
// PIX0  | pixel A beat (sel 2)
// PIX1  | pixel B beat (sel 3)
// DONE  | frame complete pulse
module decompress_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       mem_rd,
    input  logic       cnt_done,
    output logic       count_en,
    output logic       clear,
    output logic       len0,
    output logic       len1,
    output logic       len2,
    output logic [1:0] sel,
    output logic       vga_start,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [3:0] {
        IDLE, CLR, HDR_W, HDR_H, RD0, LD0, RD1, LD1, PIX0, RD2, LD2, PIX1, DONE
    } state_t;

`ifdef DECOMP_HEADER_EN
    localparam state_t FIRST_BEAT = HDR_W;
    localparam state_t AFTER_CLR  = HDR_W;
`else
    localparam state_t FIRST_BEAT = PIX0;
    localparam state_t AFTER_CLR  = RD0;
`endif

    state_t state, next_state;
    logic   last_pair, last, first_pend;
    logic   vga_start_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_pair  <= 1'b0;
            last       <= 1'b0;
            first_pend <= 1'b0;
            vga_start  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state     <= next_state;
            vga_start <= vga_start_next;
            done      <= (next_state == DONE);
            if (state == CLR)
                first_pend <= 1'b1;
            else if (vga_start_next)
                first_pend <= 1'b0;
            // A last word seen at LD0 is a malformed frame; carry it through LD1 so PIX0 ends it.
            if (state == LD0)
                last_pair <= cnt_done;
            else if (state == LD1)
                last_pair <= last_pair | cnt_done;
            if (state == LD2)
                last <= cnt_done;
        end
    end

    assign vga_start_next = ((state == CLR) || first_pend) &&
                            (next_state == FIRST_BEAT) && (state != FIRST_BEAT);

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        mem_rd     = 1'b0;
        count_en   = 1'b0;
        clear      = 1'b0;
        len0       = 1'b0;
        len1       = 1'b0;
        len2       = 1'b0;
        sel        = 2'd0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = CLR;
            end
            CLR: begin
                clear      = 1'b1;
                next_state = AFTER_CLR;
            end
            HDR_W: begin
                out_valid = 1'b1;
                sel       = 2'd0;
                if (out_ready) next_state = HDR_H;
            end
            HDR_H: begin
                out_valid = 1'b1;
                sel       = 2'd1;
                if (out_ready) next_state = RD0;
            end
            RD0: begin
                mem_rd     = 1'b1;
                next_state = LD0;
            end
            LD0: begin
                len0       = 1'b1;
                count_en   = 1'b1;
                next_state = RD1;
            end
            RD1: begin
                mem_rd     = 1'b1;
                next_state = LD1;
            end
            LD1: begin
                len1       = 1'b1;
                count_en   = 1'b1;
                next_state = PIX0;
            end
            PIX0: begin
                out_valid = 1'b1;
                sel       = 2'd2;
                if (out_ready) next_state = last_pair ? DONE : RD2;
            end
            RD2: begin
                mem_rd     = 1'b1;
                next_state = LD2;
            end
            LD2: begin
                len2       = 1'b1;
                count_en   = 1'b1;
                next_state = PIX1;
            end
            PIX1: begin
                out_valid = 1'b1;
                sel       = 2'd3;
                if (out_ready) next_state = last ? DONE : RD0;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: doc/decompress_ctrl.md
# decompress_ctrl

Control FSM that sequences the decompressor datapath: it clears the 18-bit address counter, steps through packed 16-bit memory words, loads the three staging registers, and steers the output mux so a downstream consumer receives a header (width, height) followed by 24-bit pixels over a valid/ready handshake. It sits directly upstream of the datapath, driving its `count_en`, `clear`, `len0..2`, `sel` and `vga_start` inputs and observing `cnt_done`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin one frame; sampled only in IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the frame completes
- `mem_rd`  out  1  memory read strobe; `rdata` valid the following cycle
- `cnt_done`  in  1  from datapath: current `r_addr` is the last word of the frame
- `count_en`  out  1  advance datapath address counter by one word
- `clear`  out  1  zero datapath address counter
- `len0`, `len1`, `len2`  out  1 each  load staging registers 0/1/2 from `rdata`
- `sel`  out  2  mux select: 0 width, 1 height, 2 pixel A `{r1[7:0],r0}`, 3 pixel B `{r2,r1[15:8]}`
- `vga_start`  out  1  one-cycle pulse on the first output beat of a frame
- `out_valid`  out  1  `mux_out` holds a valid beat
- `out_ready`  in  1  consumer accepts the beat this cycle

## Operation
- Moore FSM; all outputs decoded from the registered state except `vga_start`/`done`, which are registered pulses.
- States: IDLE, CLR, HDR_W, HDR_H, RD0, LD0, RD1, LD1, PIX0, RD2, LD2, PIX1, DONE.
- IDLE: `start`=1 -> CLR; otherwise hold.
- CLR: `clear`=1 for one cycle -> HDR_W.
- HDR_W: `out_valid`=1, `sel`=0; hold until `out_ready` -> HDR_H. HDR_H: same with `sel`=1 -> RD0.
- RDn: `mem_rd`=1, address stable -> LDn.
- LDn: `lenN`=1 and `count_en`=1 in the same cycle; `cnt_done` sampled this cycle (before the increment takes effect).
- LD0 -> RD1. LD1 -> PIX0 (latched `last_pair`=cnt_done). LD2 -> PIX1 (latched `last`=cnt_done).
- PIX0: `out_valid`=1, `sel`=2; on `out_ready`: if `last_pair` -> DONE (odd pixel count; upper byte of final word discarded), else -> RD2.
- PIX1: `out_valid`=1, `sel`=3; on `out_ready`: `last` -> DONE, else -> RD0.
- DONE: `done`=1 for one cycle -> IDLE.
- `cnt_done` high at LD0 is a malformed frame: FSM still completes RD1/LD1/PIX0 then DONE.
- `start` while busy is ignored. `sel` and `out_valid` are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset: state IDLE; `busy`, `done`, `mem_rd`, `count_en`, `clear`, `len0..2`, `vga_start`, `out_valid` = 0; `sel` = 0; `last_pair`, `last` = 0.
- Reset mid-frame returns to IDLE immediately (asynchronous); no `done` pulse; datapath counter is re-cleared by the next CLR.
- `start` sampled at edge k -> `clear` high in cycle k+1 -> first header beat (`out_valid`, `vga_start`) in cycle k+2.
- With `out_ready` tied high: header takes 2 cycles; each pixel pair takes 8 cycles (RD0..PIX1); first pixel beat 4 cycles after the last header beat's acceptance.
- Backpressure adds exactly one cycle per cycle `out_ready` is low; memory reads never issued while a beat is pending.
- `done` asserts the cycle after the final beat is accepted; `busy` drops the cycle after that.

## Configuration
- `DECOMP_HEADER_EN` defined: header beats HDR_W/HDR_H emitted as above; `vga_start` accompanies HDR_W.
- Not defined: CLR -> RD0 directly; no `sel`=0/1 beats; `vga_start` accompanies the first PIX0 beat.

## Test plan
- Reset during PIX1 with `out_valid` high -> all outputs 0 in same cycle, state IDLE, no `done`.
- 4x2 frame (12 words, `cnt_done` at word 11), `out_ready`=1, header enabled -> beats sel 0,1,then 2,3 x4; 10 beats; `done` 1 cycle after 10th acceptance; 12 `mem_rd` and 12 `count_en` pulses.
- 3x1 frame (5 words, `cnt_done` at word 4) -> pixel beats sel 2,3,2; DONE directly from PIX0; 5 reads.
- `out_ready` low 3 cycles on first PIX0 -> `sel`=2, `out_valid`=1 held 4 cycles; no `mem_rd` during stall; frame length +3 cycles.
- `start` pulsed during busy -> ignored; second frame only after pulse seen in IDLE.
- `DECOMP_HEADER_EN` undefined, 2x1 frame -> `clear` then first beat `sel`=2 with `vga_start`=1; only 2 beats total.
